// File: rtl/vga_bars_sequencer_if.sv
// ---------------------------------------------------------------------------
// vga_bars_sequencer_if
// Purpose : read port between the bars sequencer and the shared sine-table ROM.
// Signals : RomReq  - read request, held until ack (or timeout)
//           RomAddr - table address, stable while RomReq is high
//           RomAck  - ROM acknowledge, RomData valid in the same cycle
//           RomData - signed sine sample
// Modports: master (sequencer side), slave (ROM side)
// ---------------------------------------------------------------------------
interface vga_bars_sequencer_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 9
);
    logic                     RomReq;
    logic [ADDR_W-1:0]        RomAddr;
    logic                     RomAck;
    logic signed [DATA_W-1:0] RomData;

    modport master (output RomReq, output RomAddr, input RomAck, input RomData);
    modport slave  (input RomReq, input RomAddr, output RomAck, output RomData);
endinterface

// File: rtl/vga_bars_sequencer.sv
// ---------------------------------------------------------------------------
// vga_bars_sequencer
// Purpose : per-frame controller for the demo-bars split line. On a qualified
//           frame tick it reads one sine sample from the shared ROM, scales it
//           by an arithmetic right shift and registers it onto o_SplitLine.
// Ports   : i_Clk, i_Rst_L (sync, active low)
//           i_NewFrameTick, i_Enable, i_Reverse, i_FramesPerStep,
//           i_PhaseStep, i_AmpShift        - animation controls
//           rom_if (master)                - ROM req/addr/ack/data
//           o_SplitLine, o_SplitValid      - scaled sample and update strobe
//           o_Busy, o_FrameOverrun         - fetch status / tick-while-busy
//           o_Timeout                      - ack timeout pulse
// Option  : `define BARS_TIMEOUT_EN to abort a fetch after TIMEOUT_CYCLES
//           cycles without ack; otherwise FETCH waits forever and
//           o_Timeout is tied low.
// ---------------------------------------------------------------------------
module vga_bars_sequencer #(
    parameter int unsigned TABLE_LEN      = 120,
    parameter int unsigned ADDR_W         = 7,
`ifdef BARS_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 16,
`endif
    parameter int unsigned DATA_W         = 9
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_NewFrameTick,
    input  logic                     i_Enable,
    input  logic                     i_Reverse,
    input  logic [3:0]               i_FramesPerStep,
    input  logic [3:0]               i_PhaseStep,
    input  logic [1:0]               i_AmpShift,
    vga_bars_sequencer_if.master     rom_if,
    output logic signed [DATA_W-1:0] o_SplitLine,
    output logic                     o_SplitValid,
    output logic                     o_Busy,
    output logic                     o_FrameOverrun,
    output logic                     o_Timeout
);
    typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

    localparam logic [ADDR_W:0] LEN = (ADDR_W+1)'(TABLE_LEN);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        index_q, index_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [3:0]               fcnt_q, fcnt_d;
    logic [1:0]               shift_q, shift_d;
    logic signed [DATA_W-1:0] split_q, split_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    logic                     qual_tick;
    logic [4:0]               fps_eff;
    logic [ADDR_W:0]          idx_w, step_w, fwd_sum, fwd_next, rev_next;

`ifdef BARS_TIMEOUT_EN
    localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           to_q, to_d;
`endif

    always_comb begin
        qual_tick = i_NewFrameTick & i_Enable;
        fps_eff   = (i_FramesPerStep == 4'd0) ? 5'd1 : {1'b0, i_FramesPerStep};

        // One extra bit of headroom so index+step and index+LEN never overflow;
        // step < TABLE_LEN means a single wrap correction is enough.
        idx_w    = {1'b0, index_q};
        step_w   = (ADDR_W+1)'(i_PhaseStep);
        fwd_sum  = idx_w + step_w;
        fwd_next = (fwd_sum >= LEN) ? fwd_sum - LEN : fwd_sum;
        rev_next = (idx_w < step_w) ? idx_w + LEN - step_w : idx_w - step_w;

        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        fcnt_d  = fcnt_q;
        shift_d = shift_q;
        split_d = split_q;
        valid_d = 1'b0;
        ovr_d   = 1'b0;
`ifdef BARS_TIMEOUT_EN
        tcnt_d  = '0;
        to_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (qual_tick) begin
                    if (({1'b0, fcnt_q} + 5'd1) >= fps_eff) begin
                        fcnt_d  = '0;
                        addr_d  = index_q;
                        shift_d = i_AmpShift;
                        state_d = FETCH;
                    end else begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end
            end
            FETCH: begin
                if (qual_tick) begin
                    ovr_d = 1'b1;
                end
                if (rom_if.RomAck) begin
                    split_d = $signed(rom_if.RomData) >>> shift_q;
                    valid_d = 1'b1;
                    index_d = ADDR_W'(i_Reverse ? rev_next : fwd_next);
                    state_d = IDLE;
                end
`ifdef BARS_TIMEOUT_EN
                else if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            index_q <= '0;
            addr_q  <= '0;
            fcnt_q  <= '0;
            shift_q <= '0;
            split_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef BARS_TIMEOUT_EN
            tcnt_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
            shift_q <= shift_d;
            split_q <= split_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef BARS_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign rom_if.RomReq   = (state_q == FETCH);
    assign rom_if.RomAddr  = addr_q;
    assign o_SplitLine     = split_q;
    assign o_SplitValid    = valid_q;
    assign o_Busy          = (state_q != IDLE);
    assign o_FrameOverrun  = ovr_q;
`ifdef BARS_TIMEOUT_EN
    assign o_Timeout       = to_q;
`else
    assign o_Timeout       = 1'b0;
`endif
endmodule

// File: tb/tb_vga_bars_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vga_bars_sequencer
// Purpose : self-checking bench for vga_bars_sequencer. A directed vector
//           table, hand-written corner sequences and a randomized run are all
//           checked against a frame-level reference model using modulo index
//           arithmetic and floor-division scaling. A ROM responder answers
//           requests with programmable or random latency.
// ---------------------------------------------------------------------------
module tb_vga_bars_sequencer;
    localparam int TLEN = 120;

    logic              clk;
    logic              rst_n, tick, en, rev;
    logic [3:0]        fps, step;
    logic [1:0]        amp;
    logic signed [8:0] split;
    logic              valid, busy, ovr, tout;

    vga_bars_sequencer_if #(.ADDR_W(7), .DATA_W(9)) rif ();

    vga_bars_sequencer #(.TABLE_LEN(TLEN), .ADDR_W(7), .DATA_W(9)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_NewFrameTick(tick), .i_Enable(en),
        .i_Reverse(rev), .i_FramesPerStep(fps), .i_PhaseStep(step),
        .i_AmpShift(amp), .rom_if(rif), .o_SplitLine(split),
        .o_SplitValid(valid), .o_Busy(busy), .o_FrameOverrun(ovr),
        .o_Timeout(tout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int rom [TLEN];

    // ROM responder controls
    bit rsp_en     = 1'b1;
    bit rand_delay = 1'b0;
    bit spur       = 1'b0;
    int ack_delay  = 0;

    initial begin
        int  wcnt, cur_delay;
        bit  req_seen;
        rif.RomAck  = 1'b0;
        rif.RomData = '0;
        wcnt = 0; cur_delay = 0; req_seen = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rif.RomReq && rsp_en) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    wcnt      = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 6)) : ack_delay;
                end
                rif.RomAck  = (wcnt == cur_delay);
                rif.RomData = 9'(rom[rif.RomAddr]);
                wcnt++;
            end else begin
                req_seen    = 1'b0;
                rif.RomAck  = spur && ($urandom_range(0, 3) == 0);
                rif.RomData = 9'($urandom_range(0, 511));
            end
        end
    end

    // Reference model: frame-level view of the sequencer
    bit m_busy = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_to = 1'b0;
    int m_idx = 0, m_fcnt = 0, m_addr = 0, m_shift = 0, m_split = 0, m_wait = 0;

    task automatic model_update(input bit ack);
        int lim, s, d, p;
        m_valid = 1'b0; m_ovr = 1'b0; m_to = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_idx = 0; m_fcnt = 0; m_addr = 0;
            m_shift = 0; m_split = 0; m_wait = 0;
        end else if (m_busy) begin
            if (tick && en) m_ovr = 1'b1;
            if (ack) begin
                d = rom[m_addr];
                p = 1 << m_shift;
                m_split = (d >= 0) ? d / p : -((-d + p - 1) / p);
                m_valid = 1'b1;
                m_busy  = 1'b0;
                s = rev ? -int'(step) : int'(step);
                m_idx = ((m_idx + s) % TLEN + TLEN) % TLEN;
            end
`ifdef BARS_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == 16) begin
                    m_busy = 1'b0;
                    m_to   = 1'b1;
                end
            end
`endif
        end else if (tick && en) begin
            lim = (fps == 0) ? 1 : int'(fps);
            m_fcnt++;
            if (m_fcnt >= lim) begin
                m_fcnt = 0; m_addr = m_idx; m_shift = int'(amp);
                m_busy = 1'b1; m_wait = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
        end
    endtask

    logic              obs_req, obs_valid, obs_ovr, obs_to, obs_busy;
    logic [6:0]        obs_addr;
    logic signed [8:0] obs_split;

    // One clock cycle: sample and check away from the edge, then advance the model.
    task automatic cyc();
        @(negedge clk);
        obs_req = rif.RomReq; obs_addr = rif.RomAddr; obs_split = split;
        obs_valid = valid; obs_ovr = ovr; obs_to = tout; obs_busy = busy;
        chk("busy",    obs_busy,  m_busy);
        chk("req",     obs_req,   m_busy);
        chk("addr",    obs_addr,  m_addr);
        chk("split",   obs_split, m_split);
        chk("valid",   obs_valid, m_valid);
        chk("overrun", obs_ovr,   m_ovr);
        chk("timeout", obs_to,    m_to);
        model_update(rif.RomAck);
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic tick_once();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic wait_req(input string nm, input int expa);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            if (obs_req) begin
                got = 1'b1;
                chk(nm, obs_addr, expa);
            end
        end
        if (!got) chk({nm, "_noreq"}, obs_req, 1);
    endtask

    task automatic wait_valid(input string nm, input int exps);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc();
            if (obs_valid) begin
                got = 1'b1;
                chk(nm, obs_split, exps);
            end
        end
        if (!got) chk({nm, "_novalid"}, obs_valid, 1);
    endtask

    typedef struct {
        bit rst; bit tk; bit en; bit rv; int fps; int stp; int amp;
        bit e_req; int e_addr; int e_split; bit e_valid;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int nv, no, nreq, nto, held, to_addr;

        // rst tk en rv fps stp amp | req addr split valid
        tbl[0]  = '{0, 0, 1, 0, 1, 1, 0,  0, 0,  0, 0};
        tbl[1]  = '{1, 1, 1, 0, 1, 1, 0,  0, 0,  0, 0};
        tbl[2]  = '{1, 0, 1, 0, 1, 1, 0,  1, 0,  0, 0};
        tbl[3]  = '{1, 0, 1, 0, 1, 1, 0,  0, 0, 10, 1};
        tbl[4]  = '{1, 1, 1, 0, 1, 1, 0,  0, 0, 10, 0};
        tbl[5]  = '{1, 0, 1, 0, 1, 1, 0,  1, 1, 10, 0};
        tbl[6]  = '{1, 0, 1, 0, 1, 1, 0,  0, 1, 21, 1};
        tbl[7]  = '{1, 0, 1, 0, 1, 1, 0,  0, 1, 21, 0};
        tbl[8]  = '{1, 1, 1, 0, 3, 1, 0,  0, 1, 21, 0};
        tbl[9]  = '{1, 0, 1, 0, 3, 1, 0,  0, 1, 21, 0};
        tbl[10] = '{1, 1, 1, 0, 3, 1, 0,  0, 1, 21, 0};
        tbl[11] = '{1, 1, 1, 0, 3, 1, 0,  0, 1, 21, 0};
        tbl[12] = '{1, 0, 1, 0, 3, 1, 0,  1, 2, 21, 0};
        tbl[13] = '{1, 0, 1, 0, 3, 1, 0,  0, 2, 33, 1};
        tbl[14] = '{1, 1, 1, 0, 3, 1, 0,  0, 2, 33, 0};
        tbl[15] = '{1, 1, 1, 0, 3, 1, 0,  0, 2, 33, 0};
        tbl[16] = '{1, 1, 1, 0, 3, 1, 0,  0, 2, 33, 0};
        tbl[17] = '{1, 0, 1, 0, 3, 1, 0,  1, 3, 33, 0};
        tbl[18] = '{1, 0, 1, 0, 3, 1, 0,  0, 3, -7, 1};

        for (int i = 0; i < TLEN; i++) rom[i] = int'($urandom_range(0, 511)) - 256;
        rom[0] = 10; rom[1] = 21; rom[2] = 33; rom[3] = -7;
        rom[117] = -200; rom[112] = -200;

        rst_n = 1'b0; tick = 1'b0; en = 1'b1; rev = 1'b0;
        fps = 4'd1; step = 4'd1; amp = 2'd0;

        // Directed vector table: reset, FPS=1 fetches, FPS=3 decimation
        for (int i = 0; i < 19; i++) begin
            rst_n = tbl[i].rst; tick = tbl[i].tk; en = tbl[i].en; rev = tbl[i].rv;
            fps = 4'(tbl[i].fps); step = 4'(tbl[i].stp); amp = 2'(tbl[i].amp);
            cyc();
            chk("tbl_req",   obs_req,   tbl[i].e_req);
            chk("tbl_addr",  obs_addr,  tbl[i].e_addr);
            chk("tbl_split", obs_split, tbl[i].e_split);
            chk("tbl_valid", obs_valid, tbl[i].e_valid);
        end
        tick = 1'b0;

        // Index wrap in both directions
        rst_n = 1'b0; run(2); rst_n = 1'b1;
        fps = 4'd1; amp = 2'd0;
        rev = 1'b1; step = 4'd2; tick_once(); wait_req("rev_from0", 0);   run(2);
        rev = 1'b0; step = 4'd5; tick_once(); wait_req("fwd_118", 118);   run(2);
        rev = 1'b1; step = 4'd1; tick_once(); wait_req("fwd_wrap3", 3);   run(2);
        rev = 1'b1; step = 4'd5; tick_once(); wait_req("rev_2", 2);       run(2);
        amp = 2'd2;             tick_once(); wait_req("rev_wrap117", 117);
        wait_valid("amp2_neg200", -50);

        // Shift latched at fetch start
        ack_delay = 3; amp = 2'd1;
        tick_once(); amp = 2'd3;
        wait_valid("amp_latched", -100);
        run(2);

        // Enable low: ticks ignored
        en = 1'b0; nreq = 0;
        for (int i = 0; i < 6; i++) begin tick = 1'b1; cyc(); nreq += int'(obs_req); end
        tick = 1'b0; en = 1'b1;
        chk("disabled_noreq", nreq, 0);

        // Delayed ack with a tick during the wait
        ack_delay = 5; nv = 0; no = 0;
        for (int i = 0; i < 16; i++) begin
            tick = (i == 0 || i == 3);
            cyc();
            nv += int'(obs_valid); no += int'(obs_ovr);
        end
        tick = 1'b0;
        chk("ovr_pulses", no, 1);
        chk("ovr_valids", nv, 1);

        // Reset in the middle of a fetch
        ack_delay = 0; rsp_en = 1'b0;
        tick_once(); run(3);
        chk("midfetch_req", obs_req, 1);
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        chk("rst_req",   obs_req,   0);
        chk("rst_busy",  obs_busy,  0);
        chk("rst_split", obs_split, 0);
        rsp_en = 1'b1;
        tick_once(); wait_req("rst_index0", 0); run(2);

`ifdef BARS_TIMEOUT_EN
        // No ack: fetch abandoned after the timeout
        rsp_en = 1'b0; held = int'(obs_split); nreq = 0; nto = 0; to_addr = -1;
        for (int i = 0; i < 30; i++) begin
            tick = (i == 0);
            cyc();
            nreq += int'(obs_req); nto += int'(obs_to);
            if (obs_req) to_addr = int'(obs_addr);
        end
        tick = 1'b0;
        chk("to_req_cycles", nreq, 16);
        chk("to_pulses", nto, 1);
        chk("to_split_held", obs_split, held);
        rsp_en = 1'b1;
        tick_once(); wait_req("to_index_held", to_addr); run(2);
`else
        held = 0; to_addr = 0; nto = 0;
`endif

        // Randomized traffic against the model
        rand_delay = 1'b1; spur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            tick  = ($urandom_range(0, 3) == 0);
            en    = ($urandom_range(0, 7) != 0);
            rev   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) fps = 4'($urandom_range(0, 4));
            step  = 4'($urandom_range(0, 15));
            amp   = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
